// File: rtl/operand_exec.sv
// operand_exec: execute stage for two-byte logic-mode instructions sharing the memory port with fetch.
// Optional mem_ack watchdog is compiled in when AY8_MEM_TIMEOUT_EN is defined.

module operand_exec #(
  parameter int DW             = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [DW-1:0] opcode,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] acc_in,
  output logic          busy,
  output logic          done,
  output logic          illegal,
  output logic          mem_req,
  output logic [DW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          pc_inc,
  output logic          alu_mode,
  output logic [3:0]    alu_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_cn,
  input  logic [DW-1:0] alu_f,
  input  logic          alu_zf,
  output logic          acc_we,
  output logic [DW-1:0] acc_wdata,
  output logic          zf_we,
  output logic          zf_wdata,
  output logic          timeout
);

  typedef enum logic [2:0] {IDLE, OPR, REF, ALU, WB} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] opcode_q, opcode_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] operand_q, operand_d;
  logic [DW-1:0] result_q, result_d;
  logic          zf_q, zf_d;
  logic          illegal_q, illegal_d;

`ifdef AY8_MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
  logic          expired;

  // Counts request cycles without ack; the final allowed cycle aborts the read.
  assign expired = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cycles
  end
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      pc_q      <= '0;
      acc_q     <= '0;
      operand_q <= '0;
      result_q  <= '0;
      zf_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      pc_q      <= pc_d;
      acc_q     <= acc_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      zf_q      <= zf_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    pc_d      = pc_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    result_d  = result_q;
    zf_d      = zf_q;
    illegal_d = illegal_q;
    busy      = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    pc_inc    = 1'b0;
    alu_mode  = 1'b0;
    alu_sel   = 4'h0;
    alu_a     = '0;
    alu_b     = '0;
    alu_cn    = 1'b0;
    acc_we    = 1'b0;
    acc_wdata = '0;
    zf_we     = 1'b0;
    zf_wdata  = 1'b0;
    timeout   = 1'b0;
`ifdef AY8_MEM_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          opcode_d = opcode;
          pc_d     = pc_in;
          acc_d    = acc_in;
`ifdef AY8_MEM_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          // Only classes 0 (immediate) and 1 (reference) are executable.
          if (opcode[7:5] == 3'b000) begin
            illegal_d = 1'b0;
            state_d   = OPR;
          end else begin
            illegal_d = 1'b1;
            state_d   = WB;
          end
        end
      end
      OPR: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          operand_d = mem_rdata;
          pc_inc    = 1'b1;
          state_d   = opcode_q[4] ? REF : ALU;
        end
`ifdef AY8_MEM_TIMEOUT_EN
        else if (expired) begin
          timeout_d = 1'b1;
          state_d   = WB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      REF: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = operand_q;
        if (mem_ack) begin
          operand_d = mem_rdata;
          state_d   = ALU;
        end
`ifdef AY8_MEM_TIMEOUT_EN
        else if (expired) begin
          timeout_d = 1'b1;
          state_d   = WB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      ALU: begin
        busy     = 1'b1;
        alu_mode = 1'b1;
        alu_sel  = opcode_q[3:0];
        alu_a    = acc_q;
        alu_b    = operand_q;
        alu_cn   = 1'b1;
        result_d = alu_f;
        zf_d     = alu_zf;
        state_d  = WB;
      end
      WB: begin
        busy    = 1'b1;
        done    = 1'b1;
        illegal = illegal_q;
        state_d = IDLE;
`ifdef AY8_MEM_TIMEOUT_EN
        timeout = timeout_q;
`endif
        // Aborted or unsupported instructions complete without touching ACC/ZF.
        if (!illegal_q && !timeout) begin
          acc_we    = 1'b1;
          acc_wdata = result_q;
          if (opcode_q[3:0] != 4'h0) begin
            zf_we    = 1'b1;
            zf_wdata = zf_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
